uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

UART receiver with an integrated baud-tick generator. It turns an asynchronous serial line into parallel bytes with parity and framing checks. It sits between the external RX pin and the host-side register or FIFO logic. One system clock (100 MHz nominal) drives both the tick generator and the receive state machine.

## Interface
- No parameters; system clock fixed at 100 MHz for the period constants below.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial input, idle high; asynchronous to clk
- base_sel  in  1  base baud: 0 = 76.8 kbaud (base period 1302 cycles), 1 = 460.8 kbaud (217 cycles)
- div_ratio  in  3  baud divider exponent; bit period P = base period << div_ratio
- data_size  in  1  0 = 7 data bits, 1 = 8 data bits
- parity_en  in  1  1 = parity bit present after data
- parity_mode  in  2  11 odd, 10 even, 01 mark (parity bit must be 1), 00 space (must be 0)
- stop_bit_size  in  1  0 = one stop bit, 1 = two stop bits
- data  out  8  last received word, LSB first on line; bit 7 = 0 in 7-bit mode
- err_crc  out  1  parity error flag of last frame
- err_frame  out  1  framing error flag of last frame
- ready  out  1  high when idle (no frame in progress)
- new_data  out  1  one-cycle pulse when a frame completes

## Operation
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Tick generator: counter enabled only while a frame is in progress; held at 0 with no ticks when disabled. On enable, the first sample tick occurs P/2 (integer floor) cycles later, then one tick every P cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: ready=1. A falling edge of rx_s (previous 1, current 0) latches data_size, parity_en, parity_mode, stop_bit_size, base_sel and div_ratio, enables the generator, and moves to START. Config changes mid-frame are ignored.
- START, at the first tick: if rx_s=1 (glitch), return to IDLE silently with no flags and no pulse; else go to DATA.
- DATA: sample one bit per tick into a shift register, LSB first, 7 or 8 bits; then go to PARITY if parity_en, else STOP.
- PARITY: sample one bit; compute expected parity and set pending crc error on mismatch.
  - Odd: data bits XOR parity bit = 1. Even: data bits XOR parity bit = 0. Mark: expected 1. Space: expected 0.
  - The XOR covers 7 or 8 bits per data_size.
- STOP: sample 1 or 2 stop bits; any stop sample = 0 sets pending frame error.
- Frame end (after the last stop sample): update data, err_crc and err_frame together; pulse new_data; disable the generator; return to IDLE.
- When parity_en=0, err_crc is written 0 at frame end.
- Flags and data hold until the next completed frame.
- After a framing error with rx still low, no new start is accepted until rx_s returns high and falls again (edge detection).

## Timing
- Reset values: data=0, err_crc=0, err_frame=0, ready=1, new_data=0; FSM in IDLE; generator disabled. Reset mid-frame aborts the frame with no pulse.
- Start detection: 2–3 clk after the line falls (synchronizer plus edge register). ready drops the cycle after detection.
- Sample k (k=0 is the start bit) occurs floor(P/2) + k·P cycles after detection.
- Frame of N bits = 1 + data bits + parity + stop bits.
  - new_data is high for exactly one cycle, the cycle after sample N−1.
  - data and flags are valid in that same cycle.
  - ready rises in that same cycle.
- Example: P=217, 8 data, parity, 1 stop gives N=11; new_data comes 108 + 10·217 + 1 = 2279 cycles after detection.
- Bit-time tolerance: ±3 % line rate error must still sample mid-bit correctly.

## Test plan
- base_sel=1, div=0, 8-bit, parity mark, 1 stop; send 0x95 with parity bit 1 at 2160 ns/bit -> new_data pulse, data=0x95, err_crc=0, err_frame=0.
- Same frame with parity bit 0 -> data=0x95, err_crc=1, err_frame=0.
- Same frame with stop bit 0, then line high -> data=0x95, err_frame=1, err_crc=0; no spurious second frame.
- 7-bit, even parity, 2 stops, base_sel=0, div=1 (P=2604); send 0x55 with parity 0 -> data=0x55, no errors; then odd mode with the same bits -> err_crc=1.
- rx low pulse of 20 cycles, then high -> no new_data, ready returns high, outputs unchanged.
- Assert rst halfway through a frame -> all outputs at reset values; next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: UART receiver with built-in baud tick generator, parity and framing checks
module uart_rx_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       base_sel,
  input  logic [2:0] div_ratio,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  output logic [7:0] data,
  output logic       err_crc,
  output logic       err_frame,
  output logic       ready,
  output logic       new_data
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic        rx_m_q, rx_s_q, rx_p_q;
  logic [2:0]  state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] per, lim;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        sz_q, pen_q, stop_q, base_q;
  logic [1:0]  pmode_q;
  logic [2:0]  div_q;
  logic        perr_q, perr_d, ferr_q, ferr_d;
  logic [7:0]  data_d;
  logic        crc_d, frm_d, nd_d;
  logic        fall, tick;
  assign fall  = rx_p_q & ~rx_s_q;
  assign ready = state_q == IDLE;
  assign per   = (base_q ? 18'd217 : 18'd1302) << div_q;
  // first tick lands mid start bit, later ticks one bit period apart
  assign lim   = (state_q == START) ? (per >> 1) - 18'd1 : per - 18'd1;
  assign tick  = !ready && cnt_q == lim;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data;
    crc_d   = err_crc;
    frm_d   = err_frame;
    nd_d    = 1'b0;
    cnt_d   = (ready || tick) ? 18'd0 : cnt_q + 18'd1;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        bit_d   = 3'd0;
        shift_d = 8'd0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: if (tick) state_d = rx_s_q ? IDLE : DATA;
      DATA: if (tick) begin
        shift_d[bit_q] = rx_s_q;
        bit_d = bit_q + 3'd1;
        if (bit_q == {2'b11, sz_q}) begin
          bit_d   = 3'd0;
          state_d = pen_q ? PARITY : STOP;
        end
      end
      // unused bit 7 stays 0 in 7-bit mode, so the XOR spans the right width
      PARITY: if (tick) begin
        perr_d  = (pmode_q[1] ? ^shift_q ^ rx_s_q : rx_s_q) ^ pmode_q[0];
        state_d = STOP;
      end
      STOP: if (tick) begin
        ferr_d = ferr_q | ~rx_s_q;
        bit_d  = bit_q + 3'd1;
        if (bit_q[0] == stop_q) begin
          state_d = IDLE;
          data_d  = shift_q;
          crc_d   = pen_q & perr_q;
          frm_d   = ferr_d;
          nd_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 18'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      sz_q      <= 1'b0;
      pen_q     <= 1'b0;
      pmode_q   <= 2'd0;
      stop_q    <= 1'b0;
      base_q    <= 1'b0;
      div_q     <= 3'd0;
      data      <= 8'd0;
      err_crc   <= 1'b0;
      err_frame <= 1'b0;
      new_data  <= 1'b0;
    end else begin
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      rx_p_q    <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data      <= data_d;
      err_crc   <= crc_d;
      err_frame <= frm_d;
      new_data  <= nd_d;
      if (ready && fall) begin
        sz_q    <= data_size;
        pen_q   <= parity_en;
        pmode_q <= parity_mode;
        stop_q  <= stop_bit_size;
        base_q  <= base_sel;
        div_q   <= div_ratio;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: randomized scoreboard bench for uart_rx_unit (10 time units per clock)
module tb_uart_rx_unit;
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic       base_sel = 1'b1, data_size = 1'b1, parity_en = 1'b0, stop_bit_size = 1'b0;
  logic [2:0] div_ratio = 3'd0;
  logic [1:0] parity_mode = 2'd0;
  logic [7:0] data;
  logic       err_crc, err_frame, ready, new_data;
  typedef struct {
    logic [7:0] d;
    logic       crc;
    logic       frm;
    int         start;
    int         lat;
  } exp_t;
  exp_t sb[$];
  exp_t last;
  int   cyc = 0, tests = 0, fails = 0;
  uart_rx_unit dut (
    .clk(clk), .rst(rst), .rx(rx), .base_sel(base_sel), .div_ratio(div_ratio),
    .data_size(data_size), .parity_en(parity_en), .parity_mode(parity_mode),
    .stop_bit_size(stop_bit_size), .data(data), .err_crc(err_crc), .err_frame(err_frame),
    .ready(ready), .new_data(new_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && new_data) begin
      if (sb.size() == 0) chk("unexpected_new_data", 1, 0);
      else begin
        exp_t e;
        int lat;
        e = sb.pop_front();
        last = e;
        lat = cyc - e.start;
        chk("data", data, e.d);
        chk("err_crc", err_crc, e.crc);
        chk("err_frame", err_frame, e.frm);
        chk("ready_at_end", ready, 1);
        tests++;
        if (lat < e.lat + 2 || lat > e.lat + 4) begin
          fails++;
          $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lat + 2, e.lat + 4);
        end
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic pbit, input logic [1:0] stops,
                      input int bit_t, input bit scr);
    exp_t e;
    int nb, nst, per, ones;
    logic pen;
    logic [7:0] dm;
    nb   = data_size ? 8 : 7;
    nst  = stop_bit_size ? 2 : 1;
    pen  = parity_en;
    dm   = data_size ? d : {1'b0, d[6:0]};
    ones = $countones(dm) + int'(pbit);
    e.d  = dm;
    e.crc = !pen ? 1'b0 :
            parity_mode == 2'b11 ? (ones % 2 != 1) :
            parity_mode == 2'b10 ? (ones % 2 != 0) : (pbit != parity_mode[0]);
    e.frm = !stops[0] || (nst == 2 && !stops[1]);
    per   = (base_sel ? 217 : 1302) << div_ratio;
    e.lat = per / 2 + (nb + int'(pen) + nst) * per;
    @(negedge clk);
    rx = 1'b0;
    e.start = cyc;
    sb.push_back(e);
    #(bit_t);
    if (scr) {base_sel, div_ratio, data_size, parity_en, parity_mode, stop_bit_size} = 9'($urandom);
    for (int i = 0; i < nb; i++) begin
      rx = dm[i];
      #(bit_t);
    end
    if (pen) begin
      rx = pbit;
      #(bit_t);
    end
    for (int s = 0; s < nst; s++) begin
      rx = stops[s];
      #(bit_t);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("frame_drained", sb.size(), 0);
  endtask
  initial begin
    #(950000);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_err_crc", err_crc, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_ready", ready, 1);
    chk("rst_new_data", new_data, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // 8-bit, mark parity, one stop, P=217, line slightly fast
    {base_sel, div_ratio, data_size, parity_en, parity_mode, stop_bit_size} = {1'b1, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0};
    send(8'h95, 1'b1, 2'b11, 2160, 1'b0);
    repeat (20) @(negedge clk);
    send(8'h95, 1'b0, 2'b11, 2160, 1'b0);
    repeat (20) @(negedge clk);
    send(8'h95, 1'b1, 2'b10, 2160, 1'b0);
    repeat (400) @(negedge clk);
    chk("no_spurious_ready", ready, 1);
    // 7-bit even parity, two stops at P=2604, then odd mode with the same bits
    {base_sel, div_ratio, data_size, parity_en, parity_mode, stop_bit_size} = {1'b0, 3'd1, 1'b0, 1'b1, 2'b10, 1'b1};
    send(8'h55, 1'b0, 2'b11, 26040, 1'b0);
    repeat (20) @(negedge clk);
    {base_sel, div_ratio, parity_mode} = {1'b1, 3'd0, 2'b11};
    send(8'h55, 1'b0, 2'b11, 2170, 1'b0);
    repeat (20) @(negedge clk);
    // start glitch of 20 cycles
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy", ready, 0);
    repeat (170) @(negedge clk);
    chk("glitch_ready", ready, 1);
    chk("glitch_data", data, last.d);
    chk("glitch_crc", err_crc, last.crc);
    chk("glitch_frm", err_frame, last.frm);
    // reset in the middle of a frame
    {data_size, parity_en, stop_bit_size} = 3'b100;
    rx = 1'b0;
    #(2170 * 4);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data", data, 0);
    chk("midrst_err_crc", err_crc, 0);
    chk("midrst_err_frame", err_frame, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_new_data", new_data, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send(8'hA3, 1'b0, 2'b11, 2170, 1'b0);
    // random frames with config scrambled after the start bit
    for (int n = 0; n < 6; n++) begin
      int per, bt;
      logic [1:0] st;
      repeat (10 + $urandom_range(0, 20)) @(negedge clk);
      {data_size, parity_en, parity_mode, stop_bit_size} = 5'($urandom);
      base_sel  = 1'b1;
      div_ratio = 3'($urandom_range(0, 1));
      per = 217 << div_ratio;
      bt  = per * 10 * (1000 + $urandom_range(0, 50) - 25) / 1000;
      st  = {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0};
      send(8'($urandom), 1'($urandom), st, bt, 1'b1);
    end
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
